// File: rtl/cbfp_denorm_if.sv
// Streaming bus between the CBFP denormalizer and its neighbours:
// a normalized mantissa/index input side and a fixed-point output side.
interface cbfp_denorm_if #(
  parameter int BW_IN  = 11,
  parameter int BW_IDX = 5,
  parameter int BW_OUT = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [BW_IN-1:0]  in_re;
  logic signed [BW_IN-1:0]  in_im;
  logic        [BW_IDX-1:0] in_idx0;
  logic        [BW_IDX-1:0] in_idx1;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [BW_OUT-1:0] out_re;
  logic signed [BW_OUT-1:0] out_im;
  logic                     out_last;

  modport slave (
    input  in_valid, in_re, in_im, in_idx0, in_idx1, out_ready,
    output in_ready, out_valid, out_re, out_im, out_last
  );

  modport master (
    output in_valid, in_re, in_im, in_idx0, in_idx1, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_last
  );
endinterface

// File: rtl/cbfp_denorm.sv
// CBFP denormalizer: undoes the two-stage block scaling, saturates to BW_OUT,
// tracks frame position, flags index changes inside a block and counts clips.
module cbfp_denorm #(
  parameter int N          = 512,
  parameter int BLOCK_SIZE = 64,
  parameter int BW_IN      = 11,
  parameter int BW_IDX     = 5,
  parameter int BW_OUT     = 16,
  parameter int SCALE_BIAS = 9
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  cbfp_denorm_if.slave  bus,
  output logic          err_idx,
  output logic [15:0]   sat_cnt
);
  localparam int CNT_W  = $clog2(N);
  localparam int TOT_W  = BW_IDX + 1;
  localparam int EXP_W  = TOT_W + 2;
  localparam int WIDE_W = BW_IN + SCALE_BIAS;

  localparam logic signed [BW_OUT-1:0] OUT_MAX = {1'b0, {(BW_OUT-1){1'b1}}};
  localparam logic signed [BW_OUT-1:0] OUT_MIN = {1'b1, {(BW_OUT-1){1'b0}}};
  localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-BW_OUT){1'b0}}, OUT_MAX};
  localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-BW_OUT){1'b1}}, OUT_MIN};

  logic                     w_adv;
  logic                     w_accept;
  logic [TOT_W-1:0]         w_total;
  logic                     w_blk_start;

  logic [CNT_W-1:0]         r_cnt;
  logic [TOT_W-1:0]         r_blk_total;
  logic                     r_err;
  logic [15:0]              r_sat;

  logic                     r_s1_valid;
  logic signed [BW_IN-1:0]  r_s1_re;
  logic signed [BW_IN-1:0]  r_s1_im;
  logic signed [EXP_W-1:0]  r_s1_exp;
  logic                     r_s1_last;

  logic                     r_out_valid;
  logic signed [BW_OUT-1:0] r_out_re;
  logic signed [BW_OUT-1:0] r_out_im;
  logic                     r_out_last;

  logic signed [BW_IN-1:0]  w_s1_x [2];
  logic signed [BW_OUT-1:0] w_y    [2];
  logic [1:0]               w_clip;
  logic [1:0]               w_clip_n;
  logic [16:0]              w_sat_sum;

  // Whole pipeline freezes only while a valid output is being refused.
  assign w_adv       = !(r_out_valid && !bus.out_ready);
  assign w_accept    = bus.in_valid && w_adv;
  assign w_total     = TOT_W'(bus.in_idx0) + TOT_W'(bus.in_idx1);
  assign w_blk_start = (r_cnt % CNT_W'(BLOCK_SIZE)) == '0;

  assign w_s1_x[0] = r_s1_re;
  assign w_s1_x[1] = r_s1_im;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      logic signed [WIDE_W-1:0] w_ext;
      logic signed [WIDE_W-1:0] w_shift;
      logic        [EXP_W-1:0]  w_rsh;
      logic                     w_hi;
      logic                     w_lo;

      assign w_ext = {{SCALE_BIAS{w_s1_x[gi][BW_IN-1]}}, w_s1_x[gi]};
      assign w_rsh = -r_s1_exp;

      // Right shifts past the mantissa width collapse to the sign fill.
      always_comb begin
        w_shift = w_ext;
        if (!r_s1_exp[EXP_W-1])
          w_shift = w_ext << r_s1_exp;
        else if (w_rsh >= EXP_W'(BW_IN))
          w_shift = {WIDE_W{w_ext[WIDE_W-1]}};
        else
          w_shift = w_ext >>> w_rsh;
      end

      assign w_hi        = w_shift > SAT_MAX;
      assign w_lo        = w_shift < SAT_MIN;
      assign w_clip[gi]  = w_hi | w_lo;
      assign w_y[gi]     = w_hi ? OUT_MAX : (w_lo ? OUT_MIN : w_shift[BW_OUT-1:0]);
    end
  endgenerate

  assign w_clip_n  = {1'b0, w_clip[0]} + {1'b0, w_clip[1]};
  assign w_sat_sum = {1'b0, r_sat} + 17'(w_clip_n);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid  <= 1'b0;
      r_s1_re     <= '0;
      r_s1_im     <= '0;
      r_s1_exp    <= '0;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_re   <= bus.in_re;
        r_s1_im   <= bus.in_im;
        r_s1_exp  <= EXP_W'(SCALE_BIAS) - EXP_W'(w_total);
        r_s1_last <= (r_cnt == CNT_W'(N - 1));
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_re   <= w_y[0];
        r_out_im   <= w_y[1];
        r_out_last <= r_s1_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_blk_total <= '0;
    end else if (w_accept) begin
      r_cnt <= (r_cnt == CNT_W'(N - 1)) ? '0 : r_cnt + 1'b1;
      if (w_blk_start)
        r_blk_total <= w_total;
    end
  end

  // clr has priority over a same-cycle index error or clip.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err <= 1'b0;
      r_sat <= '0;
    end else if (clr) begin
      r_err <= 1'b0;
      r_sat <= '0;
    end else begin
      if (w_accept && !w_blk_start && (w_total != r_blk_total))
        r_err <= 1'b1;
      if (w_adv && r_s1_valid)
        r_sat <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_out_valid;
  assign bus.out_re    = r_out_re;
  assign bus.out_im    = r_out_im;
  assign bus.out_last  = r_out_last;
  assign err_idx       = r_err;
  assign sat_cnt       = r_sat;
endmodule

// File: tb/tb_cbfp_denorm.sv
// Self-checking bench for cbfp_denorm: directed scaling/saturation/index cases
// plus randomized traffic compared against an arithmetic reference model.
module tb_cbfp_denorm;
  logic        clk;
  logic        rstn;
  logic        clr;
  logic        err_idx;
  logic [15:0] sat_cnt;

  cbfp_denorm_if #(.BW_IN(11), .BW_IDX(5), .BW_OUT(16)) bus ();

  cbfp_denorm dut (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (clr),
    .bus    (bus),
    .err_idx(err_idx),
    .sat_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    bit last;
  } exp_t;

  exp_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     m_cnt    = 0;
  int     m_blk    = 0;
  bit     m_err    = 0;
  int     m_sat    = 0;
  int     obs_re, obs_im;
  bit     obs_last;
  int     n_last   = 0;
  int     rdy_mode = 0;
  int     rdy_cyc  = 0;
  bit     prev_stall = 0;
  longint prev_re, prev_im, prev_last;

  task automatic check(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Exact value of x * 2^(9 - total), rounded toward -inf.
  function automatic longint ref_scale(int x, int total);
    int     e;
    int     s;
    longint d;
    longint y;
    e = 9 - total;
    if (e >= 0) begin
      y = longint'(x) * (longint'(1) << e);
    end else begin
      s = -e;
      if (s > 40) s = 40;
      d = longint'(1) << s;
      y = longint'(x) / d;
      if (x < 0 && (longint'(x) % d) != 0) y = y - 1;
    end
    return y;
  endfunction

  function automatic int clip16(longint y, output bit c);
    c = 1'b0;
    if (y > 32767)  begin c = 1'b1; return 32767;  end
    if (y < -32768) begin c = 1'b1; return -32768; end
    return int'(y);
  endfunction

  // Per-cycle scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    int   tot;
    bit   c0, c1;
    if (rstn) begin
      check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      check("err_idx", err_idx, m_err);
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_re", bus.out_re, prev_re);
        check("stall_im", bus.out_im, prev_im);
        check("stall_last", bus.out_last, prev_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_re", bus.out_re, e.re);
          check("out_im", bus.out_im, e.im);
          check("out_last", bus.out_last, e.last);
          obs_re   = bus.out_re;
          obs_im   = bus.out_im;
          obs_last = bus.out_last;
          if (bus.out_last) n_last++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        tot    = int'(bus.in_idx0) + int'(bus.in_idx1);
        e.re   = clip16(ref_scale(int'(bus.in_re), tot), c0);
        e.im   = clip16(ref_scale(int'(bus.in_im), tot), c1);
        e.last = (m_cnt == 511);
        exp_q.push_back(e);
        m_sat = m_sat + int'(c0) + int'(c1);
        if (m_sat > 65535) m_sat = 65535;
        if (m_cnt % 64 == 0) m_blk = tot;
        else if (tot != m_blk) m_err = 1'b1;
        m_cnt = (m_cnt + 1) % 512;
      end
      if (clr) begin
        m_err = 1'b0;
        m_sat = 0;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_re    = bus.out_re;
      prev_im    = bus.out_im;
      prev_last  = bus.out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    rdy_cyc++;
    case (rdy_mode)
      1:       bus.out_ready = ((rdy_cyc % 4) == 0) || ((rdy_cyc % 4) == 3);
      2:       bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b1;
    endcase
  end

  task automatic send(int re, int im, int i0, int i1);
    bit acc;
    int w;
    bus.in_valid = 1'b1;
    bus.in_re    = 11'(re);
    bus.in_im    = 11'(im);
    bus.in_idx0  = 5'(i0);
    bus.in_idx1  = 5'(i1);
    w = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      w++;
    end while (!acc && w < 1000);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int w;
    bus.in_valid = 1'b0;
    w = 0;
    while (exp_q.size() != 0 && w < 4000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.in_valid = 1'b0;
    rstn = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_blk = 0;
    m_err = 1'b0;
    m_sat = 0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_re", bus.out_re, 0);
    check("rst_out_im", bus.out_im, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_err_idx", err_idx, 0);
    check("rst_sat_cnt", sat_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  function automatic int rnd_mant();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  task automatic send_frame(int bad_k);
    int i0, i1;
    for (int k = 0; k < 512; k++) begin
      if (k % 64 == 0) begin
        i0 = int'($urandom_range(0, 15));
        i1 = int'($urandom_range(0, 15));
      end
      send(rnd_mant(), rnd_mant(), i0, (k == bad_k) ? (i1 ^ 1) : i1);
    end
  endtask

  initial begin
    #2_000_000;
    check("watchdog", 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int i0, i1;
    rstn          = 1'b0;
    clr           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_re     = '0;
    bus.in_im     = '0;
    bus.in_idx0   = '0;
    bus.in_idx1   = '0;
    bus.out_ready = 1'b1;

    check("pin_up", ref_scale(100, 5), 1600);
    check("pin_down_neg", ref_scale(-300, 20), -1);
    check("pin_down_pos", ref_scale(300, 20), 0);
    check("pin_deep_neg", ref_scale(-5, 62), -1);

    @(posedge clk);
    #1;
    reset_dut();

    // Scale up with latency probe
    bus.in_valid = 1'b1;
    bus.in_re    = 11'sd100;
    bus.in_im    = -11'sd7;
    bus.in_idx0  = 5'd3;
    bus.in_idx1  = 5'd2;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("lat1_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat2_valid", bus.out_valid, 1);
    check("up_re", bus.out_re, 1600);
    check("up_im", bus.out_im, -112);
    drain();
    check("up_sat", sat_cnt, 0);

    send(-300, 300, 10, 10);
    drain();
    check("down_re", obs_re, -1);
    check("down_im", obs_im, 0);
    send(5, 0, 20, 20);
    drain();
    check("deep_re", obs_re, 0);
    check("deep_sat", sat_cnt, 0);

    // Saturation and counter ceiling
    send(1023, -1024, 0, 0);
    drain();
    check("sat_re", obs_re, 32767);
    check("sat_im", obs_im, -32768);
    check("sat_cnt_2", sat_cnt, 2);
    for (int k = 1; k < 40000; k++) send(1023, -1024, 0, 0);
    drain();
    check("sat_cnt_hold", sat_cnt, 65535);
    check("sat_cnt_model", sat_cnt, m_sat);
    pulse_clr();
    check("sat_cnt_clr", sat_cnt, 0);

    // Backpressure frame, then index-consistency frames
    reset_dut();
    rdy_mode = 1;
    n_last = 0;
    send_frame(-1);
    drain();
    check("bp_last_once", n_last, 1);
    check("bp_err_clean", err_idx, 0);
    rdy_mode = 0;
    send_frame(70);
    drain();
    check("idx_err_set", err_idx, 1);
    send_frame(-1);
    drain();
    check("idx_err_sticky", err_idx, 1);
    pulse_clr();
    check("idx_err_clr", err_idx, 0);

    // Randomized traffic with gaps and random backpressure
    reset_dut();
    rdy_mode = 2;
    i0 = 0;
    i1 = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      if (m_cnt % 64 == 0 || $urandom_range(0, 99) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          i0 = int'($urandom_range(0, 4));
          i1 = int'($urandom_range(0, 4));
        end else begin
          i0 = int'($urandom_range(0, 31));
          i1 = int'($urandom_range(0, 31));
        end
      end
      send(rnd_mant(), rnd_mant(), i0, i1);
    end
    drain();
    check("rand_sat_model", sat_cnt, m_sat);
    check("rand_err_model", err_idx, m_err);

    // Reset mid-frame with data in flight
    reset_dut();
    rdy_mode = 0;
    for (int k = 0; k < 200; k++) send(rnd_mant(), rnd_mant(), 4, 4);
    reset_dut();
    rdy_mode = 1;
    n_last = 0;
    for (int k = 0; k < 512; k++) send(rnd_mant(), rnd_mant(), 4, 5);
    drain();
    check("mid_rst_last_once", n_last, 1);
    check("mid_rst_last_final", obs_last, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cbfp_denorm.md
Name: cbfp_denorm

Overview:
- Back-end counterpart of the per-block CBFP normalizer in the FFT datapath.
- Takes normalized complex mantissas plus the shift indices recorded by two CBFP stages. Removes the combined scaling and emits full-scale fixed-point FFT output.
- Streaming: one complex sample per accepted beat. Tracks frame/block position, checks index consistency per block and counts saturations.

Parameters:
- N, 512, samples per frame
- BLOCK_SIZE, 64, samples sharing one index; N must be a multiple of BLOCK_SIZE
- BW_IN, 11, input mantissa width (signed)
- BW_IDX, 5, width of each stage index
- BW_OUT, 16, output width (signed)
- SCALE_BIAS, 9, exponent bias; applied exponent e = SCALE_BIAS - (idx0 + idx1)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- clr  in  1  sync clear of err_idx and sat_cnt
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_re  in  BW_IN  signed real mantissa
- in_im  in  BW_IN  signed imag mantissa
- in_idx0  in  BW_IDX  stage-0 shift index
- in_idx1  in  BW_IDX  stage-1 shift index
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_re  out  BW_OUT  signed denormalized real
- out_im  out  BW_OUT  signed denormalized imag
- out_last  out  1  high with the output beat of sample N-1
- err_idx  out  1  sticky: index changed inside a block
- sat_cnt  out  16  saturating count of clipped components

Behaviour:
- Reset (rstn low, async): out_valid=0, out_re=0, out_im=0, out_last=0, err_idx=0, sat_cnt=0.
- Reset also clears the sample counter to 0, the latched block index to 0 and all pipeline valid bits. Reset mid-frame discards in-flight data; the next accepted beat is sample 0.
- Pipeline: two register stages (S1, S2).
  - S1 registers the inputs and computes total = idx0 + idx1 (BW_IDX+1 bits, unsigned) and e = SCALE_BIAS - total (signed).
  - S2 registers the shifted, saturated result.
  - Latency is 2 cycles from acceptance to out_valid when out_ready stays high. Throughput is 1 beat/cycle.
- Stall: in_ready = !(out_valid && !out_ready), combinational. When stalled, S1 and S2 hold; out_* stay stable until accepted.
- Shift rule, per component x:
  - e >= 0: y = x << e, evaluated at BW_IN+SCALE_BIAS bits.
  - e < 0: y = x >>> (-e), arithmetic, truncate toward -inf. -e >= BW_IN yields 0 for x >= 0 and -1 for x < 0.
- Saturation: if y > 2^(BW_OUT-1)-1, output max positive; if y < -2^(BW_OUT-1), output min negative. Each clipped component increments sat_cnt by 1 (both re and im clipped in the same beat: +2). sat_cnt holds at 0xFFFF and never wraps.
- Frame counter: counts accepted input beats 0..N-1 and wraps to 0 after N-1. out_last travels with the beat and is high only for sample N-1.
- Block check:
  - At sample index k with k % BLOCK_SIZE == 0, latch total.
  - For any other sample in the block, total != latched value sets err_idx.
  - err_idx is sticky until clr or reset. Data still passes unmodified.
- clr: clears err_idx and sat_cnt in the next cycle. If clr and a new clip/error occur in the same cycle, clr wins and the event is dropped. clr does not affect the data path or the frame counter.
- in_valid low: bubbles propagate; the counter does not advance.

Test Plan:
- Scaling up: in_re=100, in_im=-7, idx0=3, idx1=2 (e=4) -> out_re=1600, out_im=-112 two cycles later, sat_cnt=0.
- Scaling down: in_re=-300, in_im=300, idx0=10, idx1=10 (e=-11) -> out_re=-1, out_im=0. Then idx sum 40 with in_re=5 -> out_re=0.
- Saturation: in_re=1023, in_im=-1024, idx0=idx1=0 (e=9) -> out_re=32767, out_im=-32768, sat_cnt=2. Repeat 40000 beats -> sat_cnt holds at 65535; clr -> 0.
- Backpressure: stream 512 beats with out_ready toggling 1,0,0,1 pattern.
  - Every output matches the model in order, with no loss or duplication.
  - out_re stays stable while out_valid && !out_ready.
  - out_last occurs exactly once, on beat 511.
- Index check: constant index per 64-sample block -> err_idx=0. Change idx1 at sample 70 -> err_idx=1 from the following cycle and stays set across frames until clr.
- Reset mid-frame: assert rstn low at sample 200 with data in flight -> outputs 0 immediately. After release, the next 512 beats give out_last on beat 511 of the new frame.
